// File: rtl/sb_tx_serializer.sv
// sb_tx_serializer
// Sideband TX serializer sitting behind the packet framer. Takes one framed
// phase per handshake, shifts it out LSB-first one bit per i_clk, gates the
// forwarded sideband clock while bits are on the lane, then holds an idle gap
// before signalling ser_done again.
//
// Optional build macro: SB_SER_OVERRUN_DET_EN adds a sticky o_overrun flag
// that records any strobe arriving while the serializer is busy.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | lane quiet, o_ser_done high, waiting for i_packet_valid
// ST_SHIFT | one phase bit on the lane per cycle, sideband clock enabled
// ST_GAP   | mandatory idle gap, data low and sideband clock gated

module sb_tx_serializer #(
    parameter int PHASE_W = 64,
    parameter int GAP_UI  = 32,
    parameter int CNT_W   = 7
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [PHASE_W-1:0] i_packet_phase,
    input  logic               i_packet_valid,
    output logic               o_ser_done,
    output logic               o_txdata,
    output logic               o_clk_gate_en,
`ifdef SB_SER_OVERRUN_DET_EN
    output logic               o_overrun,
`endif
    output logic               o_phase_sent
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Counter is compared against constants and cleared on every state
    // change, so it never needs to wrap.
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(PHASE_W - 1);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PHASE_W - 2);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_UI - 1);

    state_t             state;
    logic [PHASE_W-1:0] shreg;
    logic [CNT_W-1:0]   cnt;

    // Done drops in the same cycle as the strobe so the framer never sees a
    // stale done while its phase is being captured.
    assign o_ser_done = (state == ST_IDLE) && !i_packet_valid;

    // Serializer FSM: capture, shift LSB-first, then enforce the idle gap.
    // Bit0 is driven on the capture edge itself, so the remaining bits are
    // kept pre-shifted in shreg.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= ST_IDLE;
            shreg         <= '0;
            cnt           <= '0;
            o_txdata      <= 1'b0;
            o_clk_gate_en <= 1'b0;
            o_phase_sent  <= 1'b0;
        end else begin
            o_phase_sent <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_packet_valid) begin
                        shreg         <= i_packet_phase >> 1;
                        o_txdata      <= i_packet_phase[0];
                        o_clk_gate_en <= 1'b1;
                        cnt           <= '0;
                        state         <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (cnt == LAST_BIT) begin
                        o_txdata      <= 1'b0;
                        o_clk_gate_en <= 1'b0;
                        cnt           <= '0;
                        state         <= ST_GAP;
                    end else begin
                        o_txdata     <= shreg[0];
                        shreg        <= shreg >> 1;
                        cnt          <= cnt + 1'b1;
                        o_phase_sent <= (cnt == PRE_LAST);
                    end
                end
                ST_GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state         <= ST_IDLE;
                    cnt           <= '0;
                    o_txdata      <= 1'b0;
                    o_clk_gate_en <= 1'b0;
                end
            endcase
        end
    end

`ifdef SB_SER_OVERRUN_DET_EN
    // Sticky record of a strobe arriving while busy; the phase itself is dropped.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_overrun <= 1'b0;
        end else if (i_packet_valid && (state != ST_IDLE)) begin
            o_overrun <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sb_tx_serializer.sv
// Bench for sb_tx_serializer: a cycle-offset reference model checks every
// output each cycle, plus directed literal expectations for the key scenarios.
module tb_sb_tx_serializer;

    localparam int PW  = 64;
    localparam int GAP = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic [63:0] phase = '0;
    logic        ser_done, txdata, gate, sent;
`ifdef SB_SER_OVERRUN_DET_EN
    logic        overrun;
`endif

    sb_tx_serializer #(.PHASE_W(PW), .GAP_UI(GAP), .CNT_W(7)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_packet_phase (phase),
        .i_packet_valid (valid),
        .o_ser_done     (ser_done),
        .o_txdata       (txdata),
        .o_clk_gate_en  (gate),
`ifdef SB_SER_OVERRUN_DET_EN
        .o_overrun      (overrun),
`endif
        .o_phase_sent   (sent)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: outputs are a pure function of how many cycles have
    // elapsed since the last accepted strobe.
    int          last_acc = -1000;
    logic [63:0] acc_ph = '0;
    logic        ovr_m = 1'b0;

    always @(negedge clk) begin
        int   d;
        logic e_gate, e_tx, idle;
        if (!rst_n) begin
            last_acc = -1000;
            ovr_m    = 1'b0;
            chk("mdl_rst_txdata", txdata, 0);
            chk("mdl_rst_gate", gate, 0);
            chk("mdl_rst_sent", sent, 0);
            chk("mdl_rst_done", ser_done, !valid);
`ifdef SB_SER_OVERRUN_DET_EN
            chk("mdl_rst_overrun", overrun, 0);
`endif
        end else begin
            d      = cyc - last_acc;
            idle   = (d > PW + GAP);
            e_gate = (d >= 1) && (d <= PW);
            e_tx   = 1'b0;
            if (e_gate) e_tx = acc_ph[d-1];
            chk("mdl_txdata", txdata, e_tx);
            chk("mdl_gate", gate, e_gate);
            chk("mdl_sent", sent, d == PW);
            chk("mdl_done", ser_done, idle && !valid);
`ifdef SB_SER_OVERRUN_DET_EN
            chk("mdl_overrun", overrun, ovr_m);
`endif
            if (valid) begin
                if (idle) begin
                    last_acc = cyc;
                    acc_ph   = phase;
                end else begin
                    ovr_m = 1'b1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!ser_done && n < 300) begin
            step();
            n++;
        end
        chk("wait_done", ser_done, 1);
    endtask

    // Framer model: strobe ph when done, optionally inject an illegal strobe
    // at offset inj_off, and record the lane until done returns.
    task automatic send_capture(input logic [63:0] ph, input int inj_off, input logic [63:0] inj_ph,
                                output logic [63:0] w, output int g, output int fg, output int lg,
                                output int so, output int dn, output int st);
        int bn;
        wait_done();
        valid = 1'b1;
        phase = ph;
        w = '0; g = 0; fg = 0; lg = 0; so = 0; dn = 0; st = 0; bn = 0;
        for (int k = 1; k <= 150 && dn == 0; k++) begin
            step();
            valid = (k == inj_off);
            phase = (k == inj_off) ? inj_ph : ph;
            if (gate) begin
                if (bn < 64) w[bn] = txdata;
                bn++;
                g++;
                if (fg == 0) fg = k;
                lg = k;
            end else if (txdata) begin
                st++;
            end
            if (sent && so == 0) so = k;
            if (ser_done && dn == 0) dn = k;
        end
        valid = 1'b0;
    endtask

    initial begin
        logic [63:0] w, w2, ph;
        int g, fg, lg, so, dn, st;
        int g2, fg2, lg2, so2, dn2, st2;
        int cnt, inj;

        repeat (3) step();
        rst_n = 1'b1;

        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (ser_done && !txdata && !gate) cnt++;
        end
        chk("idle_quiet_cycles", cnt, 200);

        send_capture(64'h0000_0000_0000_0001, 0, '0, w, g, fg, lg, so, dn, st);
        chk("one_word", w, 64'h1);
        chk("one_first_bit_off", fg, 1);
        chk("one_gate_cycles", g, 64);
        chk("one_sent_off", so, 64);
        chk("one_done_off", dn, 97);
        chk("one_stray", st, 0);

        send_capture(64'hA5A5_F00F_1234_8001, 0, '0, w, g, fg, lg, so, dn, st);
        chk("a5_word", w, 64'hA5A5_F00F_1234_8001);
        chk("a5_gate_cycles", g, 64);
        chk("a5_stray", st, 0);

        send_capture(64'h0123_4567_89AB_CDEF, 0, '0, w, g, fg, lg, so, dn, st);
        send_capture(64'hFEDC_BA98_7654_3210, 0, '0, w2, g2, fg2, lg2, so2, dn2, st2);
        chk("b2b_hdr_word", w, 64'h0123_4567_89AB_CDEF);
        chk("b2b_low_gap", dn - lg, 33);
        chk("b2b_data_first", fg2, 1);
        chk("b2b_data_word", w2, 64'hFEDC_BA98_7654_3210);

`ifdef SB_SER_OVERRUN_DET_EN
        chk("overrun_clear", overrun, 0);
`endif
        send_capture(64'h8000_0000_0000_0C35, 11, 64'hDEAD_BEEF_DEAD_BEEF, w, g, fg, lg, so, dn, st);
        chk("ovr_word", w, 64'h8000_0000_0000_0C35);
        chk("ovr_gate_cycles", g, 64);
        chk("ovr_done_off", dn, 97);
`ifdef SB_SER_OVERRUN_DET_EN
        chk("ovr_set", overrun, 1);
        repeat (50) step();
        chk("ovr_sticky", overrun, 1);
`endif

        send_capture(64'h5555_0000_AAAA_FFFF, 96, 64'h1111_2222_3333_4444, w, g, fg, lg, so, dn, st);
        chk("gapedge_word", w, 64'h5555_0000_AAAA_FFFF);
        step();
        chk("gapedge_not_accepted", gate, 0);

        ph = 64'h0000_0000_4000_0000;
        wait_done();
        valid = 1'b1;
        phase = ph;
        step();
        valid = 1'b0;
        repeat (30) step();
        chk("rst_pre_gate", gate, 1);
        chk("rst_pre_bit30", txdata, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_gate_now", gate, 0);
        chk("rst_txdata_now", txdata, 0);
        chk("rst_sent_now", sent, 0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
`ifdef SB_SER_OVERRUN_DET_EN
        chk("rst_overrun_clear", overrun, 0);
`endif
        send_capture(64'hFFFF_FFFF_FFFF_FFFF, 0, '0, w, g, fg, lg, so, dn, st);
        chk("ones_word", w, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("ones_gate_cycles", g, 64);
        chk("ones_first_bit_off", fg, 1);

        for (int i = 0; i < 20; i++) begin
            ph  = {$urandom(), $urandom()};
            inj = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 96)) : 0;
            repeat ($urandom_range(0, 4)) step();
            send_capture(ph, inj, {$urandom(), $urandom()}, w, g, fg, lg, so, dn, st);
            chk("rnd_word", w, ph);
            chk("rnd_done_off", dn, 97);
        end

        repeat (5) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
